// File: rtl/uart_pkg.sv
// Shared UART types and constants for the transmit and receive stages.
// Holds frame geometry, line levels and the FSM state encodings.
package uart_pkg;

   localparam int DATA_BITS  = 4;
   localparam int FRAME_BITS = DATA_BITS + 2;

   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: wraps CLKS_PER_BIT-1 -> 0, cleared by restart.
// Ports: clk, rst_n (sync, active low), restart in; tick out (count==0).
module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic tick
);

   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n || restart) begin
         r_cnt <= '0;
      end else if (r_cnt == LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign tick = (r_cnt == '0);

endmodule

// File: rtl/uart_tx.sv
// Serial nibble transmitter: start, DATA_BITS LSB first, stop.
// Ports: clk, rst_n; tx_din/tx_vin/tx_rdy handshake in;
// tx_dout line, tx_vout per-bit strobe, tx_busy frame flag out.
// Macro UART_TX_HOLD_EN adds a one-entry holding register so
// frames can run back to back with no idle gap.
module uart_tx #(
   parameter int DATA_BITS    = 4,
   parameter int CLKS_PER_BIT = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] tx_din,
   input  logic                 tx_vin,
   output logic                 tx_rdy,
   output logic                 tx_dout,
   output logic                 tx_vout,
   output logic                 tx_busy
);

   import uart_pkg::*;

   localparam int FB = DATA_BITS + 2;
   localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

   tx_state_t            r_state;
   logic [FB-1:0]        r_shift;
   logic [IW-1:0]        r_idx;
   logic                 r_dout;
   logic                 r_vout;
   logic                 r_busy;

   logic                 w_tick;
   logic                 w_hs;
   logic                 w_drain;
   logic                 w_restart;
   logic [DATA_BITS-1:0] w_hold_data;

   assign w_hs = tx_vin && tx_rdy;

`ifdef UART_TX_HOLD_EN
   logic [DATA_BITS-1:0] r_hold_data;
   logic                 r_hold_vld;

   assign tx_rdy      = rst_n && !r_hold_vld;
   assign w_drain     = (r_state == TX_STOP) && w_tick && r_hold_vld;
   assign w_hold_data = r_hold_data;

   // A handshake outside IDLE always parks in the hold slot; a
   // coincident drain still clears the old entry into the shifter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_hold_data <= '0;
         r_hold_vld  <= 1'b0;
      end else if (w_hs && (r_state != TX_IDLE)) begin
         r_hold_data <= tx_din;
         r_hold_vld  <= 1'b1;
      end else if (w_drain) begin
         r_hold_vld  <= 1'b0;
      end
   end
`else
   assign tx_rdy      = rst_n && (r_state == TX_IDLE);
   assign w_drain     = 1'b0;
   assign w_hold_data = '0;
`endif

   // The counter runs one cycle ahead of the registered line, so a
   // tick marks the cycle whose edge launches the next bit. It is
   // parked at zero in IDLE and released on the accepting cycle.
   assign w_restart =
      ((r_state == TX_IDLE) && !w_hs) ||
      ((r_state == TX_STOP) && w_tick && !w_drain);

   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (w_restart),
      .tick    (w_tick)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= TX_IDLE;
         r_shift <= '0;
         r_idx   <= '0;
         r_dout  <= IDLE_LEVEL;
         r_vout  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_vout <= 1'b0;
         unique case (r_state)
            TX_IDLE: begin
               if (w_hs) begin
                  r_state <= TX_START;
                  r_shift <= {STOP_BIT, tx_din, START_BIT};
                  r_dout  <= START_BIT;
                  r_vout  <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end
            TX_START: begin
               if (w_tick) begin
                  r_state <= TX_DATA;
                  r_idx   <= '0;
                  r_dout  <= r_shift[1];
                  r_shift <= r_shift >> 1;
                  r_vout  <= 1'b1;
               end
            end
            TX_DATA: begin
               if (w_tick) begin
                  // After the last data bit, r_shift[1] is the stop bit
                  r_dout  <= r_shift[1];
                  r_shift <= r_shift >> 1;
                  r_vout  <= 1'b1;
                  if (r_idx == LAST_IDX) begin
                     r_state <= TX_STOP;
                  end else begin
                     r_idx <= r_idx + IW'(1);
                  end
               end
            end
            TX_STOP: begin
               if (w_tick) begin
                  if (w_drain) begin
                     r_state <= TX_START;
                     r_shift <= {STOP_BIT, w_hold_data, START_BIT};
                     r_dout  <= START_BIT;
                     r_vout  <= 1'b1;
                  end else begin
                     r_state <= TX_IDLE;
                     r_dout  <= IDLE_LEVEL;
                     r_busy  <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= TX_IDLE;
            end
         endcase
      end
   end

   assign tx_dout = r_dout;
   assign tx_vout = r_vout;
   assign tx_busy = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: one instance at 1 clock/bit, one at 3 clocks/bit.
// Line expectations come from a per-cycle queue built from frame rules.
module tb_uart_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       vin;
   logic [3:0] din;
   logic       sel;

   logic vin1, rdy1, dout1, vout1, busy1;
   logic vin3, rdy3, dout3, vout3, busy3;
   logic rdy, dout, vout, busy;

   assign vin1 = vin && !sel;
   assign vin3 = vin && sel;
   assign rdy  = sel ? rdy3  : rdy1;
   assign dout = sel ? dout3 : dout1;
   assign vout = sel ? vout3 : vout1;
   assign busy = sel ? busy3 : busy1;

   uart_tx #(.DATA_BITS(4), .CLKS_PER_BIT(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .tx_din(din), .tx_vin(vin1),
      .tx_rdy(rdy1), .tx_dout(dout1), .tx_vout(vout1), .tx_busy(busy1)
   );

   uart_tx #(.DATA_BITS(4), .CLKS_PER_BIT(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .tx_din(din), .tx_vin(vin3),
      .tx_rdy(rdy3), .tx_dout(dout3), .tx_vout(vout3), .tx_busy(busy3)
   );

   typedef struct packed {
      logic dout;
      logic vout;
   } bit_t;

   typedef struct {
      logic [3:0] din;
      logic       sel;
      logic [5:0] line;
   } vec_t;

   bit_t       exp_q[$];
   logic [3:0] sent_q[$];
   int         strobe_cyc[$];

   int         n_chk = 0;
   int         n_pass = 0;
   int         cyc = 0;
   logic       hs = 1'b0;
   int         rx_pos = -1;
   logic [3:0] rx_bits = '0;
   logic [3:0] rx_last = '0;
   int         n_rx = 0;
   logic [5:0] cap_bits;
   int         cap_n;
   int         cap_busy;

   task automatic chk(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
   endtask

   task automatic push_frame(input logic [3:0] d);
      int   cpb;
      logic f;
      cpb = sel ? 3 : 1;
      for (int k = 0; k < 6; k++) begin
         if (k == 0) f = 1'b0;
         else if (k == 5) f = 1'b1;
         else f = d[k-1];
         for (int j = 0; j < cpb; j++) exp_q.push_back('{dout: f, vout: (j == 0)});
      end
   endtask

   task automatic rx_observe();
      logic [3:0] want;
      if (vout !== 1'b1) return;
      if (rx_pos < 0) begin
         if (dout === 1'b0) rx_pos = 0;
      end else if (rx_pos < 4) begin
         rx_bits[rx_pos[1:0]] = dout;
         rx_pos++;
      end else begin
         rx_pos = -1;
         chk("rx_stop", dout, 1'b1);
         n_rx++;
         rx_last = rx_bits;
         if (sent_q.size() == 0) begin
            n_chk++;
            $display("FAIL rx_unexpected cyc=%0d got=%0h want=none", cyc, rx_bits);
         end else begin
            want = sent_q.pop_front();
            chk("rx_data", rx_bits, want);
         end
      end
   endtask

   task automatic cycle();
      bit_t e;
      logic erdy;
      int   n;
      int   cpb;
      @(negedge clk);
      cpb = sel ? 3 : 1;
      n = exp_q.size();
      e = (n == 0) ? '{dout: 1'b1, vout: 1'b0} : exp_q[0];
`ifdef UART_TX_HOLD_EN
      erdy = rst_n && (n <= 6 * cpb);
`else
      erdy = rst_n && (n == 0);
`endif
      chk("dout", dout, e.dout);
      chk("vout", vout, e.vout);
      chk("busy", busy, n != 0);
      chk("rdy", rdy, erdy);
      if (vout === 1'b1) begin
         strobe_cyc.push_back(cyc);
         if (cap_n < 6) cap_bits[cap_n] = dout;
         cap_n++;
      end
      if (busy === 1'b1) cap_busy++;
      rx_observe();
      hs = vin && erdy;
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
         exp_q.delete();
         sent_q.delete();
         rx_pos = -1;
      end else begin
         if (n != 0) void'(exp_q.pop_front());
         if (hs) begin
            push_frame(din);
            sent_q.push_back(din);
         end
      end
      #1;
   endtask

   task automatic send(input logic [3:0] d, output int acc);
      vin = 1'b1;
      din = d;
      acc = -1;
      for (int k = 0; k < 200; k++) begin
         cycle();
         if (hs) begin
            acc = cyc - 1;
            break;
         end
      end
      vin = 1'b0;
      if (acc < 0) begin
         n_chk++;
         $display("FAIL accept_timeout cyc=%0d got=none want=accept", cyc);
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 300 && exp_q.size() != 0; k++) cycle();
      if (exp_q.size() != 0) begin
         n_chk++;
         $display("FAIL drain_timeout cyc=%0d got=%0d want=0", cyc, exp_q.size());
      end
      cycle();
      cycle();
   endtask

   task automatic clr_cap();
      cap_bits = '0;
      cap_n = 0;
      cap_busy = 0;
      strobe_cyc.delete();
   endtask

   vec_t vecs[6];
   int   acc, acc2, rx0;

   initial begin
      vecs[0] = '{din: 4'hA, sel: 1'b0, line: 6'b110100};
      vecs[1] = '{din: 4'h5, sel: 1'b1, line: 6'b101010};
      vecs[2] = '{din: 4'h3, sel: 1'b0, line: 6'b100110};
      vecs[3] = '{din: 4'hC, sel: 1'b1, line: 6'b111000};
      vecs[4] = '{din: 4'hF, sel: 1'b0, line: 6'b111110};
      vecs[5] = '{din: 4'h0, sel: 1'b1, line: 6'b100000};

      sel = 1'b0;
      rst_n = 1'b0;
      vin = 1'b1;
      din = 4'hA;
      clr_cap();
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) cycle();
      rst_n = 1'b1;
      vin = 1'b0;
      for (int i = 0; i < 5; i++) cycle();
      chk("reset_no_rx", n_rx, 0);

      for (int i = 0; i < 6; i++) begin
         sel = vecs[i].sel;
         clr_cap();
         send(vecs[i].din, acc);
         drain();
         chk("vec_line", cap_bits, vecs[i].line);
         chk("vec_strobes", cap_n, 6);
         chk("vec_busy_cycles", cap_busy, sel ? 18 : 6);
         if (strobe_cyc.size() > 0)
            chk("vec_latency", strobe_cyc[0] - acc, 1);
         chk("vec_rx", rx_last, vecs[i].din);
      end

      sel = 1'b0;
      clr_cap();
      send(4'h3, acc);
      send(4'hC, acc2);
      drain();
      chk("b2b_strobes", strobe_cyc.size(), 12);
      if (strobe_cyc.size() >= 7) begin
`ifdef UART_TX_HOLD_EN
         chk("b2b_spacing", strobe_cyc[6] - strobe_cyc[0], 6);
`else
         chk("b2b_spacing", strobe_cyc[6] - strobe_cyc[0], 7);
`endif
      end
      chk("b2b_rx", rx_last, 4'hC);

      rx0 = n_rx;
      send(4'hF, acc);
      cycle();
      cycle();
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      chk("abort_line_idle", dout, 1'b1);
      drain();
      chk("abort_no_rx", n_rx, rx0);
      send(4'h1, acc);
      drain();
      chk("post_abort_rx_cnt", n_rx, rx0 + 1);
      chk("post_abort_rx", rx_last, 4'h1);

`ifndef UART_TX_HOLD_EN
      send(4'h9, acc);
      vin = 1'b1;
      din = 4'h2;
      cycle();
      chk("bp_rdy_low", rdy, 1'b0);
      cycle();
      send(4'h7, acc2);
      chk("bp_wait", acc2 - acc, 7);
      drain();
      chk("bp_value", rx_last, 4'h7);
`endif

      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         for (int i = 0; i < 150; i++) begin
            vin = ($urandom_range(0, 2) == 0);
            din = 4'($urandom);
            cycle();
         end
         vin = 1'b0;
         drain();
      end
      chk("all_delivered", sent_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
